// File: rtl/comparator_seq_nb.sv
// comparator_seq_nb: multi-cycle magnitude comparator.
// Compares two WIDTH-bit operands CHUNK bits per cycle, most significant
// chunk first. It uses a start/busy/done handshake and returns registered
// F_eq/F_gt/F_lt flags.
// SIGNED = 1 flips the operand MSBs at capture. The offset-binary values
// then compare correctly as unsigned numbers.
// Optional macro COMP_EARLY_EXIT_EN: when defined, the compare finishes on the
// first differing chunk. When undefined, every compare takes NCHUNK cycles.
`timescale 1ns/1ps

module comparator_seq_nb #(
    parameter int WIDTH  = 16,   // must be a multiple of CHUNK
    parameter int CHUNK  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             F_eq,
    output logic             F_gt,
    output logic             F_lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Flipping the MSB maps two's complement onto offset binary.
    localparam logic [WIDTH-1:0] SIGN_MASK =
        SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_q, gt_d;     // sticky decision: A chunk was larger
    logic             lt_q, lt_d;     // sticky decision: B chunk was larger
    logic             f_eq_q, f_eq_d;
    logic             f_gt_q, f_gt_d;
    logic             f_lt_q, f_lt_d;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             dec_gt, dec_lt;
    logic             finish;
    logic             accept;

    // Select the chunk pointed to by idx_q from both captured operands.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first. Otherwise a path that leaves it unassigned infers a latch.
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Next-state logic: capture on start, step through chunks, publish the result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        f_eq_d  = f_eq_q;
        f_gt_d  = f_gt_q;
        f_lt_d  = f_lt_q;

        // Only the first differing chunk (from the top) decides the result.
        dec_gt = gt_q;
        dec_lt = lt_q;
        if (!gt_q && !lt_q && (chunk_a != chunk_b)) begin
            dec_gt = (chunk_a > chunk_b);
            dec_lt = (chunk_a < chunk_b);
        end

`ifdef COMP_EARLY_EXIT_EN
        finish = (idx_q == '0) || dec_gt || dec_lt;
`else
        finish = (idx_q == '0);
`endif

        // start is honoured only when no compare is in flight.
        accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        if (accept) begin
            state_d = S_BUSY;
            a_d     = A ^ SIGN_MASK;
            b_d     = B ^ SIGN_MASK;
            idx_d   = IDX_W'(NCHUNK - 1);
            gt_d    = 1'b0;
            lt_d    = 1'b0;
        end else begin
            case (state_q)
                S_BUSY: begin
                    gt_d = dec_gt;
                    lt_d = dec_lt;
                    if (finish) begin
                        state_d = S_DONE;
                        f_gt_d  = dec_gt;
                        f_lt_d  = dec_lt;
                        f_eq_d  = !(dec_gt || dec_lt);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, operand and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand registers are plain flops, not a memory array.
            // Clearing them costs nothing and keeps the reset state fully defined.
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            f_eq_q  <= 1'b0;
            f_gt_q  <= 1'b0;
            f_lt_q  <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments so every register samples
            // pre-edge values. Evaluation order then cannot matter.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            f_eq_q  <= f_eq_d;
            f_gt_q  <= f_gt_d;
            f_lt_q  <= f_lt_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign done = (state_q == S_DONE);
    assign F_eq = f_eq_q;
    assign F_gt = f_gt_q;
    assign F_lt = f_lt_q;

endmodule

// File: tb/tb_comparator_seq_nb.sv
// tb_comparator_seq_nb: scoreboard bench for comparator_seq_nb.
// It drives an unsigned and a signed instance from the same stimulus.
// Each accepted start pushes the expected flags and the completion edge onto
// a queue. A monitor on the falling edge pops the queue whenever done is seen.
`timescale 1ns/1ps

module tb_comparator_seq_nb;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;

    logic busy_u, done_u, eq_u, gt_u, lt_u;
    logic busy_s, done_s, eq_s, gt_s, lt_s;

    comparator_seq_nb #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .busy(busy_u), .done(done_u), .F_eq(eq_u), .F_gt(gt_u), .F_lt(lt_u)
    );

    comparator_seq_nb #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .busy(busy_s), .done(done_s), .F_eq(eq_s), .F_gt(gt_s), .F_lt(lt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] exp_u;      // {eq, gt, lt} unsigned
        logic [2:0] exp_s;      // {eq, gt, lt} signed
        int         done_edge;  // edge after which done must be high
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         edge_cnt = 0;
    logic [2:0] last_u = 3'b000;
    logic [2:0] last_s = 3'b000;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference flags straight from integer comparison.
    function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input bit sgn);
        if (sgn) begin
            if ($signed(a) > $signed(b)) return 3'b010;
            if ($signed(a) < $signed(b)) return 3'b001;
        end else begin
            if (a > b) return 3'b010;
            if (a < b) return 3'b001;
        end
        return 3'b100;
    endfunction

    // Edges from acceptance to done: 1 + equal leading chunks with early exit.
    function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] diff;
        int               top;
        int               lat;
        diff = a ^ b;
        top  = -1;
        for (int p = 0; p < WIDTH; p++)
            if (diff[p]) top = p;
        lat = (top < 0) ? NCHUNK : NCHUNK - top / CHUNK;
`ifdef COMP_EARLY_EXIT_EN
        return lat;
`else
        return (lat > 0) ? NCHUNK : NCHUNK;
`endif
    endfunction

    // Monitor: pop and compare on done, and watch that flags hold between completions.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            last_u = 3'b000;
            last_s = 3'b000;
        end else if (done_u || done_s) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, done_u, done_s}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_both", {30'd0, done_u, done_s}, 32'd3);
                check("done_edge", edge_cnt, e.done_edge);
                check("busy_at_done", {30'd0, busy_u, busy_s}, 32'd0);
                last_u = e.exp_u;
                last_s = e.exp_s;
            end
        end else if (exp_q.size() > 0 && exp_q[0].done_edge <= edge_cnt) begin
            e = exp_q.pop_front();
            check("done_missing", {30'd0, done_u, done_s}, 32'd3);
        end
        check("flags_unsigned", {29'd0, eq_u, gt_u, lt_u}, {29'd0, last_u});
        check("flags_signed",   {29'd0, eq_s, gt_s, lt_s}, {29'd0, last_s});
    end

    // Issue one compare starting now (just after an edge); optionally re-pulse start mid-BUSY.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
        exp_t e;
        int   lat;
        lat   = ref_latency(a, b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        e.exp_u     = ref_flags(a, b, 1'b0);
        e.exp_s     = ref_flags(a, b, 1'b1);
        e.done_edge = edge_cnt + lat;
        exp_q.push_back(e);
        check("busy_after_accept", {30'd0, busy_u, busy_s}, 32'd3);
        start = poke;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            a_in  = WIDTH'($urandom);
            b_in  = WIDTH'($urandom);
            if (k < lat) check("busy_during", {30'd0, busy_u, busy_s}, 32'd3);
            else         check("busy_dropped", {30'd0, busy_u, busy_s}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Abort a compare with reset just after its second edge.
    task automatic reset_mid_compare();
        a_in  = 16'h1234;
        b_in  = 16'h1235;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs",
              {22'd0, busy_u, done_u, eq_u, gt_u, lt_u, busy_s, done_s, eq_s, gt_s, lt_s}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {22'd0, busy_u, done_u, eq_u, gt_u, lt_u, busy_s, done_s, eq_s, gt_s, lt_s}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        issue(16'h0000, 16'h0800, 1'b0);
        issue(16'hA100, 16'h0800, 1'b0);   // back-to-back from DONE
        idle(2);
        issue(16'h0089, 16'h0089, 1'b0);
        idle(1);
        issue(16'hFFFF, 16'h8000, 1'b0);
        idle(1);
        issue(16'h7000, 16'h9000, 1'b1);   // mid-BUSY start ignored
        issue(16'h0001, 16'h0001, 1'b1);
        reset_mid_compare();
        issue(16'h0003, 16'h0001, 1'b0);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            issue(ra, rb, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
